ihex_encoder: RTL and testbench

Converts a stream of addressed bytes into Intel HEX text, one ASCII character at a time. It is the transmit-side counterpart of the ihex decoder and shares that block's write-handshake style. Upstream logic, typically a memory dump sequencer, pushes bytes. Downstream logic, typically a UART transmitter or file writer, consumes characters.

---
 rtl/ihex_encoder.sv | 255 +++++++++++++++++++++++++
 tb/tb_ihex_encoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ihex_encoder.sv
// Packs addressed bytes into Intel HEX records and streams them as uppercase ASCII, one char per accepted write_done.
// Emits a type-04 record whenever the upper address changes; finish appends an optional type-05 record, then EOF.
module ihex_encoder #(
    parameter int RECORD_BYTES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we_in,
    input  logic [7:0]  data_in,
    input  logic [31:0] address_in,
    input  logic        flush,
    input  logic        finish,
    input  logic        start_valid,
    input  logic [31:0] start_address,
    output logic        ready_out,
    output logic        we_out,
    output logic [7:0]  char_out,
    input  logic        write_done,
    output logic        done
);
    localparam int         AW    = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
    localparam logic [7:0] REC_N = 8'(RECORD_BYTES);

    typedef enum logic [2:0] {
        COLLECT, EMIT_ELA, EMIT_DATA, EMIT_START, EMIT_EOF, DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  buf_q [RECORD_BYTES];
    logic [31:0] base_q;
    logic [7:0]  count_q;
    logic [15:0] ela_q;
    logic        ela_vld_q;
    logic        hold_vld_q;
    logic [7:0]  hold_dat_q;
    logic [31:0] hold_addr_q;
    logic        fin_q;
    logic        pend_q;
    logic        sv_q;
    logic [31:0] sa_q;
    logic [9:0]  idx_q;
    logic [7:0]  csum_q;
    logic        we_out_q;
    logic        ready_q;
    logic        done_q;
    logic [7:0]  char_q;

    logic [7:0]  rec_len, rec_type, data_byte, cur_byte, nxt_char;
    logic [15:0] rec_addr;
    logic [9:0]  last_idx, nxt_idx, byte_k, data_k, payload_end;
    logic [3:0]  nib;
    logic        hi_nib, add_csum;

    logic [31:0] base_end, base_d;
    logic [7:0]  count_d;
    logic        contig, take, app, disc, full, trig_data, stale_c, stale_h;
    logic        char_acc, rec_end, reload;
    logic        buf_we;
    logic [AW-1:0] buf_wa;
    logic [7:0]  buf_wd;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character sequencer: idx_q is the char on char_out; byte k of the record sits at chars 2k+1, 2k+2.
    always_comb begin
        rec_len  = 8'd0;
        rec_addr = 16'd0;
        rec_type = 8'h01;
        case (state_q)
            EMIT_ELA:   begin rec_len = 8'd2; rec_type = 8'h04; end
            EMIT_DATA:  begin rec_len = count_q; rec_addr = base_q[15:0]; rec_type = 8'h00; end
            EMIT_START: begin rec_len = 8'd4; rec_type = 8'h05; end
            default:    ;
        endcase
        last_idx    = {1'b0, rec_len, 1'b0} + 10'd12;
        nxt_idx     = idx_q + 10'd1;
        byte_k      = {1'b0, idx_q[9:1]};
        data_k      = byte_k - 10'd4;
        hi_nib      = ~idx_q[0];
        payload_end = {2'b00, rec_len} + 10'd4;
        data_byte   = 8'h00;
        case (state_q)
            EMIT_ELA:  data_byte = data_k[0] ? ela_q[7:0] : ela_q[15:8];
            EMIT_DATA: begin
                if (data_k < 10'(RECORD_BYTES)) data_byte = buf_q[data_k[AW-1:0]];
            end
            EMIT_START: begin
                case (data_k[1:0])
                    2'd0:    data_byte = sa_q[31:24];
                    2'd1:    data_byte = sa_q[23:16];
                    2'd2:    data_byte = sa_q[15:8];
                    default: data_byte = sa_q[7:0];
                endcase
            end
            default: ;
        endcase
        case (byte_k)
            10'd0:   cur_byte = rec_len;
            10'd1:   cur_byte = rec_addr[15:8];
            10'd2:   cur_byte = rec_addr[7:0];
            10'd3:   cur_byte = rec_type;
            default: cur_byte = (byte_k == payload_end) ? (8'd0 - csum_q) : data_byte;
        endcase
        nib = hi_nib ? cur_byte[7:4] : cur_byte[3:0];
        if (nxt_idx == last_idx)              nxt_char = 8'h0A;
        else if (nxt_idx == last_idx - 10'd1) nxt_char = 8'h0D;
        else                                  nxt_char = hex_char(nib);
        add_csum = hi_nib && (byte_k < payload_end);
    end

    always_comb begin
        base_end  = base_q + {24'd0, count_q};
        contig    = (address_in == base_end) && (address_in[31:16] == base_q[31:16]);
        take      = (state_q == COLLECT) && we_in;
        app       = take && ((count_q == 8'd0) || contig);
        disc      = take && !app;
        count_d   = count_q + {7'd0, app};
        base_d    = (count_q == 8'd0) ? address_in : base_q;
        full      = app && (count_d == REC_N);
        trig_data = full || disc || ((state_q == COLLECT) && (flush || finish) && (count_d != 8'd0));
        stale_c   = !ela_vld_q || (base_d[31:16] != ela_q);
        stale_h   = !ela_vld_q || (hold_addr_q[31:16] != ela_q);
        char_acc  = we_out_q && write_done;
        rec_end   = char_acc && (idx_q == last_idx);
        reload    = rec_end && (state_q == EMIT_DATA) && hold_vld_q;
        buf_we    = app || reload;
        buf_wa    = app ? count_q[AW-1:0] : '0;
        buf_wd    = app ? data_in : hold_dat_q;
    end

    always_ff @(posedge clock) begin
        if (buf_we) buf_q[buf_wa] <= buf_wd;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= COLLECT;
            base_q      <= 32'd0;
            count_q     <= 8'd0;
            ela_q       <= 16'd0;
            ela_vld_q   <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_dat_q  <= 8'd0;
            hold_addr_q <= 32'd0;
            fin_q       <= 1'b0;
            pend_q      <= 1'b0;
            sv_q        <= 1'b0;
            sa_q        <= 32'd0;
            idx_q       <= 10'd0;
            csum_q      <= 8'd0;
            we_out_q    <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            char_q      <= 8'h00;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (app) begin
                        count_q <= count_d;
                        base_q  <= base_d;
                    end
                    if (disc) begin
                        hold_vld_q  <= 1'b1;
                        hold_dat_q  <= data_in;
                        hold_addr_q <= address_in;
                        pend_q      <= flush && !finish;
                    end
                    if (finish) begin
                        fin_q <= 1'b1;
                        sv_q  <= start_valid;
                        sa_q  <= start_address;
                    end
                    if (trig_data || finish) begin
                        ready_q  <= 1'b0;
                        we_out_q <= 1'b1;
                        char_q   <= 8'h3A;
                        idx_q    <= 10'd0;
                        csum_q   <= 8'd0;
                    end
                    if (trig_data) begin
                        if (stale_c) begin
                            state_q   <= EMIT_ELA;
                            ela_q     <= base_d[31:16];
                            ela_vld_q <= 1'b1;
                        end else begin
                            state_q <= EMIT_DATA;
                        end
                    end else if (finish) begin
                        state_q <= start_valid ? EMIT_START : EMIT_EOF;
                    end
                end
                EMIT_ELA, EMIT_DATA, EMIT_START, EMIT_EOF: begin
                    if (char_acc && !rec_end) begin
                        idx_q  <= nxt_idx;
                        char_q <= nxt_char;
                        if (add_csum) csum_q <= csum_q + cur_byte;
                    end else if (rec_end) begin
                        // Default: chain straight into the next record's ':'.
                        char_q <= 8'h3A;
                        idx_q  <= 10'd0;
                        csum_q <= 8'd0;
                        case (state_q)
                            EMIT_ELA: state_q <= EMIT_DATA;
                            EMIT_DATA: begin
                                count_q <= 8'd0;
                                if (hold_vld_q) begin
                                    hold_vld_q <= 1'b0;
                                    pend_q     <= 1'b0;
                                    base_q     <= hold_addr_q;
                                    count_q    <= 8'd1;
                                    if (fin_q || pend_q || (REC_N == 8'd1)) begin
                                        if (stale_h) begin
                                            state_q   <= EMIT_ELA;
                                            ela_q     <= hold_addr_q[31:16];
                                            ela_vld_q <= 1'b1;
                                        end else begin
                                            state_q <= EMIT_DATA;
                                        end
                                    end else begin
                                        state_q  <= COLLECT;
                                        we_out_q <= 1'b0;
                                        ready_q  <= 1'b1;
                                        char_q   <= 8'h00;
                                    end
                                end else if (fin_q) begin
                                    state_q <= sv_q ? EMIT_START : EMIT_EOF;
                                end else begin
                                    state_q  <= COLLECT;
                                    we_out_q <= 1'b0;
                                    ready_q  <= 1'b1;
                                    char_q   <= 8'h00;
                                end
                            end
                            EMIT_START: state_q <= EMIT_EOF;
                            default: begin
                                state_q  <= DONE;
                                we_out_q <= 1'b0;
                                done_q   <= 1'b1;
                                char_q   <= 8'h00;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_out = ready_q;
    assign we_out    = we_out_q;
    assign char_out  = char_q;
    assign done      = done_q;
endmodule

// File: tb/tb_ihex_encoder.sv
// Randomized bench for ihex_encoder: a queue-based record model predicts the exact character stream.
module tb_ihex_encoder;
    localparam int RB = 16;

    logic        clock = 1'b0;
    logic        reset, we_in, flush, finish, start_valid, write_done;
    logic [7:0]  data_in;
    logic [31:0] address_in, start_address;
    logic        ready_out, we_out, done;
    logic [7:0]  char_out;

    int n_checks = 0;
    int n_fail   = 0;
    int wd_mode  = 0;   // 0: always accept, 1: random stalls, 2: hold write_done low

    logic [7:0]  exp_q[$];
    logic [7:0]  m_buf[$];
    logic [31:0] m_base;
    logic [15:0] m_ela;
    bit          m_ela_vld;

    always #5 clock = ~clock;

    ihex_encoder #(.RECORD_BYTES(RB)) dut (
        .clock(clock), .reset(reset), .we_in(we_in), .data_in(data_in),
        .address_in(address_in), .flush(flush), .finish(finish),
        .start_valid(start_valid), .start_address(start_address),
        .ready_out(ready_out), .we_out(we_out), .char_out(char_out),
        .write_done(write_done), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    endfunction

    task automatic push_hex(input logic [7:0] b);
        exp_q.push_back(asc(b[7:4]));
        exp_q.push_back(asc(b[3:0]));
    endtask

    task automatic m_record(input logic [7:0] typ, input logic [15:0] addr, input logic [7:0] d[$]);
        logic [7:0] bytes[$];
        int s = 0;
        bytes.push_back(8'(d.size()));
        bytes.push_back(addr[15:8]);
        bytes.push_back(addr[7:0]);
        bytes.push_back(typ);
        foreach (d[i]) bytes.push_back(d[i]);
        exp_q.push_back(8'h3A);
        foreach (bytes[i]) begin
            s += int'(bytes[i]);
            push_hex(bytes[i]);
        end
        push_hex(8'((256 - (s % 256)) % 256));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic m_flush();
        logic [7:0] tmp[$];
        if (m_buf.size() == 0) return;
        if (!m_ela_vld || m_base[31:16] != m_ela) begin
            m_ela     = m_base[31:16];
            m_ela_vld = 1'b1;
            tmp.push_back(m_ela[15:8]);
            tmp.push_back(m_ela[7:0]);
            m_record(8'h04, 16'h0000, tmp);
        end
        m_record(8'h00, m_base[15:0], m_buf);
        m_buf.delete();
    endtask

    task automatic m_byte(input logic [7:0] d, input logic [31:0] a);
        if (m_buf.size() != 0 && (a != m_base + 32'(m_buf.size()) || a[31:16] != m_base[31:16]))
            m_flush();
        if (m_buf.size() == 0) m_base = a;
        m_buf.push_back(d);
        if (m_buf.size() == RB) m_flush();
    endtask

    task automatic m_finish(input bit sv, input logic [31:0] sa);
        logic [7:0] tmp[$];
        logic [7:0] none[$];
        m_flush();
        if (sv) begin
            tmp.push_back(sa[31:24]);
            tmp.push_back(sa[23:16]);
            tmp.push_back(sa[15:8]);
            tmp.push_back(sa[7:0]);
            m_record(8'h05, 16'h0000, tmp);
        end
        m_record(8'h01, 16'h0000, none);
    endtask

    // Output monitor: every presented char must be the next expected one.
    always @(negedge clock) begin
        if (!reset && we_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we_out", we_out, 0);
            end else begin
                check("char", char_out, exp_q[0]);
                if (write_done) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        write_done = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            write_done = (wd_mode == 0) ? 1'b1 : (wd_mode == 2) ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    task automatic do_op(input bit we, input logic [7:0] d, input logic [31:0] a,
                         input bit fl, input bit fin, input bit sv, input logic [31:0] sa);
        int n = 0;
        while (!ready_out && n < 3000) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!ready_out) begin
            check("ready_timeout", ready_out, 1);
            return;
        end
        we_in = we; data_in = d; address_in = a; flush = fl; finish = fin;
        start_valid = sv; start_address = sa;
        if (we) m_byte(d, a);
        if (fin) m_finish(sv, sa);
        else if (fl) m_flush();
        @(posedge clock);
        #1;
        we_in = 0; flush = 0; finish = 0; start_valid = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || we_out) && n < 5000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1;
        exp_q.delete();
        m_buf.delete();
        m_ela_vld = 1'b0;
        #1;
        check("reset_we_out_async", we_out, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
    endtask

    initial begin
        logic [31:0] cur;
        int n;
        reset = 1; we_in = 0; data_in = 0; address_in = 0; flush = 0; finish = 0;
        start_valid = 0; start_address = 0; m_ela_vld = 0; m_base = 0; m_ela = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 0;
        check("rst_we_out", we_out, 0);
        check("rst_char_out", char_out, 8'h00);
        check("rst_ready_out", ready_out, 1);
        check("rst_done", done, 0);

        for (int i = 0; i < 3; i++) do_op(1, 8'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 0);
        do_op(0, 0, 0, 1, 0, 0, 0);
        check("ready_low_after_flush", ready_out, 0);
        drain("drain_flush3");
        check("ready_back_after_flush", ready_out, 1);

        for (int i = 0; i < 16; i++) do_op(1, 8'(i), 32'(i), 0, 0, 0, 0);
        check("ready_low_full", ready_out, 0);
        check("we_out_full", we_out, 1);
        drain("drain_full");

        do_op(1, 8'hAA, 32'h10, 0, 0, 0, 0);
        do_op(1, 8'hBB, 32'h20, 0, 0, 0, 0);
        check("ready_low_disc", ready_out, 0);
        drain("drain_disc");
        do_op(0, 0, 0, 1, 0, 0, 0);
        drain("drain_disc_flush");

        do_op(1, 8'h11, 32'h0001_FFFF, 0, 0, 0, 0);
        do_op(1, 8'h22, 32'h0002_0000, 0, 0, 0, 0);
        do_op(0, 0, 0, 1, 0, 0, 0);
        drain("drain_upper_cross");

        // Stall mid-line, then reset mid-line.
        for (int i = 0; i < 4; i++) do_op(1, 8'h41 + 8'(i), 32'h3000 + 32'(i), 0, 0, 0, 0);
        do_op(0, 0, 0, 1, 0, 0, 0);
        n = 0;
        while (exp_q.size() > 12 && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        wd_mode = 2;
        repeat (6) @(posedge clock);
        #1;
        check("stall_we_out", we_out, 1);
        do_reset();
        wd_mode = 0;
        check("post_reset_ready", ready_out, 1);
        do_op(1, 8'h77, 32'h0000_0005, 0, 0, 0, 0);
        do_op(0, 0, 0, 1, 0, 0, 0);
        drain("drain_after_reset");

        // Random traffic with random consumer stalls and upper-address crossings.
        wd_mode = 1;
        cur = 32'h0001_FFF0;
        for (int i = 0; i < 200; i++) begin
            int r;
            bit fl, we;
            logic [31:0] a;
            r = $urandom_range(99);
            if (r < 75)      a = cur;
            else if (r < 88) a = {cur[31:16], 16'($urandom)};
            else             a = {14'd0, 2'($urandom), 16'($urandom)};
            fl = ($urandom_range(9) == 0);
            we = !fl || ($urandom_range(1) == 0);
            do_op(we, 8'($urandom), a, fl, 0, 0, 0);
            if (we) cur = a + 32'd1;
        end
        do_op(0, 0, 0, 1, 0, 0, 0);
        drain("drain_random");
        check("ready_after_random", ready_out, 1);

        do_op(0, 0, 0, 0, 1, 1, 32'h0800_0000);
        drain("drain_finish_start");
        check("done_set", done, 1);
        check("ready_in_done", ready_out, 0);
        we_in = 1; data_in = 8'h99; address_in = 32'h0; flush = 1;
        repeat (3) @(posedge clock);
        #1;
        we_in = 0; flush = 0;
        repeat (3) @(posedge clock);
        #1;
        check("done_sticky", done, 1);
        check("we_out_in_done", we_out, 0);

        do_reset();
        check("done_cleared", done, 0);
        for (int i = 0; i < 5; i++) do_op(1, 8'($urandom), 32'h0040_0000 + 32'(i), 0, 0, 0, 0);
        do_op(1, 8'h5A, 32'h0040_0005, 0, 1, 0, 32'h0);
        drain("drain_finish_with_byte");
        check("done_set_2", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
